// File: rtl/mw_pkg.sv
// Shared definitions for the MEM->WB pipeline stage.
//
// Contents:
//   DATA_W_DEF / REG_AW_DEF : default data and register-address widths.
//   mw_state_t              : occupancy state of the skid buffer (EMPTY/ONE/TWO).
//   mw_payload_t            : payload layout at the default widths
//                             (alu_out, read_data, write_reg, reg_write, mem_to_reg).
//   payload_w()             : flat payload width for arbitrary DATA_W/REG_AW.
//                             The stage packs fields in the same order as mw_payload_t.
package mw_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } mw_state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] alu_out;
    logic [DATA_W_DEF-1:0] read_data;
    logic [REG_AW_DEF-1:0] write_reg;
    logic                  reg_write;
    logic                  mem_to_reg;
  } mw_payload_t;

  function automatic int payload_w(input int data_w, input int reg_aw);
    return 2 * data_w + reg_aw + 2;
  endfunction

endpackage

// File: rtl/mw_skid_buf.sv
// Generic 2-entry skid buffer carrying an opaque W-bit payload.
//
// Handshake: a transfer happens on a rising edge when valid and ready are both
// high on that side (in_valid & in_ready accepts, out_valid & out_ready pops).
// in_ready is a flop, so there is no combinational path from out_ready to
// in_ready. flush empties the buffer and wins over a simultaneous accept/pop.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : producer has a payload
//   in_ready     : buffer can accept (registered, low only when TWO entries held)
//   in_data      : incoming payload
//   flush        : synchronous flush of all entries
//   out_ready    : consumer takes the head entry this cycle
//   out_valid    : head entry valid
//   out_data     : head entry (main register, drives the consumer directly)
//   state        : current occupancy state, for observation
module mw_skid_buf
  import mw_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         flush,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output mw_state_t    state
);

  mw_state_t    state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q;
  logic         accept;
  logic         pop;

  assign accept    = in_valid & ready_q;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign in_ready  = ready_q;
  assign state     = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Data registers keep stale contents; only occupancy is cleared.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && !pop) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (!accept && pop) begin
            state_d = ST_EMPTY;
          end else if (accept && pop) begin
            main_d  = in_data;
          end
        end
        ST_TWO: begin
          // ready_q is low here, so accept cannot fire.
          if (pop) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      // Registered ready derived from next occupancy: low exactly when full.
      ready_q <= (state_d != ST_TWO);
    end
  end

endmodule

// File: rtl/mw_pipe_stage.sv
// MEM->WB pipeline stage with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and register-write qualification.
//
// Handshake: accept = ValidM & ReadyM, pop = ValidW & ReadyW, both taking
// effect on the rising edge. ReadyM is a flop (NOT skid_full). While
// ValidW=1 and ReadyW=0 every W output holds. FlushW empties the stage and
// drops any entry offered in the same cycle.
//
// Optional build macro MW_RESULT_MUX_EN adds ResultW (WB result mux) and
// FwdValidW (forwarding qualifier); without it the mux stays external.
//
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   ValidM / ReadyM                    : MEM side handshake
//   ALUOutM, ReadDataM, WriteRegM,
//   RegWriteM, MemtoRegM               : MEM side payload
//   FlushW                             : synchronous flush
//   ReadyW / ValidW                    : WB side handshake
//   ALUOutW, ReadDataW, WriteRegW,
//   MemtoRegW                          : head payload
//   RegWriteW                          : head write enable, 0 when ValidW=0
//   state                              : occupancy state, for observation
//   ResultW, FwdValidW                 : only with MW_RESULT_MUX_EN
module mw_pipe_stage
  import mw_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ValidM,
  output logic              ReadyM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] ReadDataM,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              FlushW,
  input  logic              ReadyW,
  output logic              ValidW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [REG_AW-1:0] WriteRegW,
  output logic              RegWriteW,
  output logic              MemtoRegW,
`ifdef MW_RESULT_MUX_EN
  output logic [DATA_W-1:0] ResultW,
  output logic              FwdValidW,
`endif
  output mw_state_t         state
);

  localparam int PW = payload_w(DATA_W, REG_AW);

  logic [PW-1:0] in_pay;
  logic [PW-1:0] head_pay;
  logic          head_reg_write;

  // Field order matches mw_payload_t.
  assign in_pay = {ALUOutM, ReadDataM, WriteRegM, RegWriteM, MemtoRegM};

  mw_skid_buf #(
    .W(PW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (ValidM),
    .in_ready  (ReadyM),
    .in_data   (in_pay),
    .flush     (FlushW),
    .out_ready (ReadyW),
    .out_valid (ValidW),
    .out_data  (head_pay),
    .state     (state)
  );

  assign {ALUOutW, ReadDataW, WriteRegW, head_reg_write, MemtoRegW} = head_pay;

  // The main register keeps stale data after a pop or flush; gating with
  // ValidW keeps an empty stage from writing the register file.
  assign RegWriteW = head_reg_write & ValidW;

`ifdef MW_RESULT_MUX_EN
  assign ResultW   = MemtoRegW ? ReadDataW : ALUOutW;
  // Writes to register 0 are architecturally discarded, so never forward them.
  assign FwdValidW = ValidW & RegWriteW & (WriteRegW != '0);
`endif

endmodule

// File: tb/tb_mw_pipe_stage.sv
// Self-checking bench for mw_pipe_stage. Directed stimulus; every accepted
// entry is pushed into an expected queue and a monitor compares each popped
// head entry against it. Directed checks cover reset, back-pressure, flush,
// write qualification and asynchronous reset.
module tb_mw_pipe_stage;
  import mw_pkg::*;

  localparam int DATA_W = DATA_W_DEF;
  localparam int REG_AW = REG_AW_DEF;
  localparam int PW     = $bits(mw_payload_t);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              ValidM;
  logic              ReadyM;
  logic [DATA_W-1:0] ALUOutM;
  logic [DATA_W-1:0] ReadDataM;
  logic [REG_AW-1:0] WriteRegM;
  logic              RegWriteM;
  logic              MemtoRegM;
  logic              FlushW;
  logic              ReadyW;
  logic              ValidW;
  logic [DATA_W-1:0] ALUOutW;
  logic [DATA_W-1:0] ReadDataW;
  logic [REG_AW-1:0] WriteRegW;
  logic              RegWriteW;
  logic              MemtoRegW;
`ifdef MW_RESULT_MUX_EN
  logic [DATA_W-1:0] ResultW;
  logic              FwdValidW;
`endif
  mw_state_t         state;

  mw_pipe_stage #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ValidM    (ValidM),
    .ReadyM    (ReadyM),
    .ALUOutM   (ALUOutM),
    .ReadDataM (ReadDataM),
    .WriteRegM (WriteRegM),
    .RegWriteM (RegWriteM),
    .MemtoRegM (MemtoRegM),
    .FlushW    (FlushW),
    .ReadyW    (ReadyW),
    .ValidW    (ValidW),
    .ALUOutW   (ALUOutW),
    .ReadDataW (ReadDataW),
    .WriteRegW (WriteRegW),
    .RegWriteW (RegWriteW),
    .MemtoRegW (MemtoRegW),
`ifdef MW_RESULT_MUX_EN
    .ResultW   (ResultW),
    .FwdValidW (FwdValidW),
`endif
    .state     (state)
  );

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: at the falling edge, a head that will be popped at the next
  // rising edge is compared with the oldest expected entry; an entry that
  // will be accepted is pushed. Flush and reset discard expectations.
  always @(negedge clk) begin : monitor
    logic [PW-1:0] act;
    logic [PW-1:0] exp;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (ValidW && ReadyW && !FlushW) begin
        act = {ALUOutW, ReadDataW, WriteRegW, RegWriteW, MemtoRegW};
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL wb_unexpected: got ALUOutW 0x%0h, required no output", ALUOutW);
        end else begin
          exp = exp_q.pop_front();
          chk("wb_head", 128'(act), 128'(exp));
        end
      end
      if (FlushW) exp_q.delete();
      else if (ValidM && ReadyM)
        exp_q.push_back({ALUOutM, ReadDataM, WriteRegM, RegWriteM, MemtoRegM});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [DATA_W-1:0] alu,
                        input logic [DATA_W-1:0] rd, input logic [REG_AW-1:0] wr,
                        input logic rw, input logic mtr);
    ValidM    = v;
    ALUOutM   = alu;
    ReadDataM = rd;
    WriteRegM = wr;
    RegWriteM = rw;
    MemtoRegM = mtr;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n  = 1'b0;
    FlushW = 1'b0;
    ReadyW = 1'b0;
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_validw",   128'(ValidW),    128'(0));
    chk("rst_regwritew",128'(RegWriteW), 128'(0));
    chk("rst_readym",   128'(ReadyM),    128'(1));
    chk("rst_aluoutw",  128'(ALUOutW),   128'(0));
    chk("rst_state",    128'(state),     128'(ST_EMPTY));
    rst_n = 1'b1;
    tick();

    // Streaming at full rate
    ReadyW = 1'b1;
    set_in(1'b1, 32'h10, 32'h1, 5'd1, 1'b1, 1'b0);
    tick();
    chk("stream_valid0", 128'(ValidW),  128'(1));
    chk("stream_alu0",   128'(ALUOutW), 128'(32'h10));
    chk("stream_ready0", 128'(ReadyM),  128'(1));
    set_in(1'b1, 32'h20, 32'h2, 5'd2, 1'b1, 1'b0);
    tick();
    chk("stream_alu1",   128'(ALUOutW), 128'(32'h20));
    chk("stream_ready1", 128'(ReadyM),  128'(1));
    set_in(1'b1, 32'h30, 32'h3, 5'd3, 1'b0, 1'b1);
    tick();
    chk("stream_alu2",   128'(ALUOutW), 128'(32'h30));
    chk("stream_ready2", 128'(ReadyM),  128'(1));
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    chk("stream_drained", 128'(ValidW), 128'(0));

    // Back-pressure fills the skid entry
    ReadyW = 1'b0;
    set_in(1'b1, 32'hA, 32'hA0, 5'd4, 1'b1, 1'b0);
    tick();
    chk("bp_one_alu", 128'(ALUOutW), 128'(32'hA));
    set_in(1'b1, 32'hB, 32'hB0, 5'd5, 1'b1, 1'b1);
    tick();
    chk("bp_two_state", 128'(state),   128'(ST_TWO));
    chk("bp_two_ready", 128'(ReadyM),  128'(0));
    chk("bp_two_alu",   128'(ALUOutW), 128'(32'hA));
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    chk("bp_hold_alu",  128'(ALUOutW), 128'(32'hA));
    chk("bp_hold_wr",   128'(WriteRegW), 128'(4));
    ReadyW = 1'b1;
    tick();
    chk("bp_release_alu",   128'(ALUOutW), 128'(32'hB));
    chk("bp_release_ready", 128'(ReadyM),  128'(1));
    chk("bp_release_state", 128'(state),   128'(ST_ONE));
    tick();
    chk("bp_drained", 128'(ValidW), 128'(0));

    // Flush from TWO with a simultaneous offer
    ReadyW = 1'b0;
    set_in(1'b1, 32'hD, 32'hD0, 5'd6, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 32'hE, 32'hE0, 5'd7, 1'b1, 1'b0);
    tick();
    chk("flush_pre_state", 128'(state), 128'(ST_TWO));
    set_in(1'b1, 32'hC, 32'hC0, 5'd8, 1'b1, 1'b0);
    FlushW = 1'b1;
    tick();
    FlushW = 1'b0;
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("flush_validw",   128'(ValidW),    128'(0));
    chk("flush_regwrite", 128'(RegWriteW), 128'(0));
    chk("flush_readym",   128'(ReadyM),    128'(1));
    chk("flush_state",    128'(state),     128'(ST_EMPTY));
    ReadyW = 1'b1;
    tick();
    tick();
    chk("flush_no_c", 128'(ValidW), 128'(0));

    // Write-enable qualification
    ReadyW = 1'b0;
    set_in(1'b1, 32'h77, 32'h70, 5'd7, 1'b1, 1'b0);
    tick();
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("wq_regwrite_on", 128'(RegWriteW), 128'(1));
    chk("wq_writereg",    128'(WriteRegW), 128'(7));
    tick();
    chk("wq_regwrite_hold", 128'(RegWriteW), 128'(1));
    ReadyW = 1'b1;
    tick();
    chk("wq_regwrite_off", 128'(RegWriteW), 128'(0));
    chk("wq_validw_off",   128'(ValidW),    128'(0));

`ifdef MW_RESULT_MUX_EN
    // Result mux and forwarding qualifier
    ReadyW = 1'b0;
    set_in(1'b1, 32'h99, 32'h55, 5'd0, 1'b1, 1'b1);
    tick();
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("mux_result_load", 128'(ResultW),   128'(32'h55));
    chk("mux_fwd_r0",      128'(FwdValidW), 128'(0));
    ReadyW = 1'b1;
    set_in(1'b1, 32'h99, 32'h55, 5'd3, 1'b1, 1'b0);
    tick();
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("mux_result_alu", 128'(ResultW),   128'(32'h99));
    chk("mux_fwd_r3",     128'(FwdValidW), 128'(1));
    tick();
    chk("mux_fwd_empty",  128'(FwdValidW), 128'(0));
`endif

    // Asynchronous reset while TWO entries are held
    ReadyW = 1'b0;
    set_in(1'b1, 32'h61, 32'h0, 5'd9, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 32'h62, 32'h0, 5'd10, 1'b1, 1'b0);
    tick();
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("arst_pre_state", 128'(state), 128'(ST_TWO));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_validw",   128'(ValidW),    128'(0));
    chk("arst_regwrite", 128'(RegWriteW), 128'(0));
    chk("arst_readym",   128'(ReadyM),    128'(1));
    chk("arst_aluoutw",  128'(ALUOutW),   128'(0));
    chk("arst_state",    128'(state),     128'(ST_EMPTY));
    tick();
    rst_n  = 1'b1;
    ReadyW = 1'b1;
    set_in(1'b1, 32'h42, 32'h4, 5'd2, 1'b1, 1'b0);
    tick();
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("post_rst_valid", 128'(ValidW),  128'(1));
    chk("post_rst_alu",   128'(ALUOutW), 128'(32'h42));
    tick();
    tick();

    chk("exp_q_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mw_pipe_stage.md
Name: mw_pipe_stage

Overview:
- Parametrised MEM→WB pipeline stage, the successor to the plain MEM/WB flip-flop bank.
- Adds a valid/ready handshake, a 2-entry skid buffer, synchronous flush and write-enable qualification.
- Sits between the data-memory stage and the register-file write port. It lets WB back-pressure (e.g. a regfile port conflict) stall MEM without a combinational ready path.

Parameters:
- DATA_W, 32, width of ALU result and memory read data.
- REG_AW, 5, destination register address width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ValidM  in  1  MEM presents a valid instruction.
- ReadyM  out  1  stage can accept; registered, equals NOT skid_full.
- ALUOutM  in  DATA_W  ALU result.
- ReadDataM  in  DATA_W  memory load data.
- WriteRegM  in  REG_AW  destination register.
- RegWriteM  in  1  register write request.
- MemtoRegM  in  1  select load data for writeback.
- FlushW  in  1  synchronous flush of all held entries.
- ReadyW  in  1  WB consumes the head entry this cycle.
- ValidW  out  1  head entry valid.
- ALUOutW  out  DATA_W  head ALU result.
- ReadDataW  out  DATA_W  head load data.
- WriteRegW  out  REG_AW  head destination.
- RegWriteW  out  1  head write enable, forced 0 when ValidW=0.
- MemtoRegW  out  1  head select.

Behaviour:
- Storage:
  - main entry drives the W outputs directly; skid entry is a second copy of the same fields.
  - State is encoded EMPTY/ONE/TWO, equivalent to main_v/skid_v.
- accept = ValidM & ReadyM.
- pop = ValidW & ReadyW.
- Reset (async, rst_n=0): state=EMPTY, ValidW=0, RegWriteW=0, ReadyM=1. All data outputs are 0 and skid contents are 0.
- Transitions, evaluated on each rising edge:
  - EMPTY: accept → ONE, main ← inputs.
  - ONE, accept & !pop → TWO, skid ← inputs.
  - ONE, !accept & pop → EMPTY.
  - ONE, accept & pop → ONE, main ← inputs.
  - ONE, neither → hold.
  - TWO: ReadyM=0 so no accept. pop → ONE, main ← skid. Otherwise hold.
- Latency: an entry accepted at edge N is visible on the W outputs after edge N, i.e. 1 cycle, when the stage was EMPTY or popping. Throughput is 1 per cycle with ReadyW held high.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- Flush: FlushW=1 at an edge sets state=EMPTY and ReadyM=1.
  - Flush has priority over a simultaneous accept or pop; the incoming entry is dropped.
  - Data registers may keep stale values, but RegWriteW must read 0.
- Qualification: RegWriteW = main.RegWrite & ValidW. A stalled or empty stage never writes the regfile.
- Hold: while ValidW=1 and ReadyW=0, every W output is stable.
- ReadyM is a flop output with no combinational path from ReadyW.
- Reset asserted mid-operation: outputs clear asynchronously regardless of clk. The first edge after release behaves as EMPTY.

Optional Feature:
- Macro: MW_RESULT_MUX_EN.
- Defined: adds output ResultW (DATA_W) = MemtoRegW ? ReadDataW : ALUOutW, combinational from the main entry. Adds output FwdValidW = ValidW & RegWriteW & (WriteRegW != 0), for hazard-unit forwarding.
- Undefined: neither port exists and the WB mux stays external.

Decomposition:
- Shared package mw_pkg holds:
  - state enum (ST_EMPTY, ST_ONE, ST_TWO);
  - default DATA_W/REG_AW constants;
  - packed struct mw_payload_t (alu_out, read_data, write_reg, reg_write, mem_to_reg) for main and skid storage.
- Natural sub-module: mw_skid_buf, a generic 2-entry payload skid buffer with valid/ready and flush. mw_pipe_stage wraps it, adding RegWrite qualification and the optional result mux.

Test Plan:
- Reset: rst_n=0 mid-stream with TWO entries held → ValidW=0, RegWriteW=0, ReadyM=1 immediately, without waiting for a clk edge.
- Streaming: ReadyW=1; ValidM every cycle with ALUOutM=0x10,0x20,0x30 → ALUOutW=0x10,0x20,0x30 on consecutive cycles; ReadyM stays 1.
- Back-pressure:
  - ReadyW=0; accept 0xA then 0xB → state TWO, ReadyM=0, ALUOutW=0xA stable.
  - Then ReadyW=1 → 0xA pops, 0xB appears next cycle, ReadyM=1.
- Flush: in TWO, assert FlushW with ValidM=1 (0xC) → next cycle ValidW=0, RegWriteW=0; 0xC never appears.
- Write qualification: RegWriteM=1, WriteRegM=7, ReadyW=0 → RegWriteW=1 only while ValidW=1; after pop with no new input, RegWriteW=0.
- MW_RESULT_MUX_EN: MemtoRegM=1, ReadDataM=0x55, ALUOutM=0x99 → ResultW=0x55. With WriteRegM=0 → FwdValidW=0.
